execute_stage: RTL and testbench

- Pipelined EX stage for the RV32IM core. Successor to the single-cycle execute block.
- Adds forwarding muxes ahead of the ALU operand muxes and an iterative RV32M multiply/divide unit with a stall handshake.
- Adds a registered EX/MEM output boundary.
- Sits between the ID/EX register and the memory stage. The hazard unit consumes stall_out.

---
 rtl/execute_pkg.sv | 42 ++++
 rtl/alu.sv | 44 ++++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 rtl/execute_stage.sv | 118 +++++++++++
 tb/tb_execute_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_pkg.sv
// Shared types for the pipelined EX stage: forwarding selects, ALU ops,
// RV32M funct3 codes and the multiply/divide sequencer states.
package execute_pkg;

    typedef enum logic [1:0] {
        REG = 2'b00,
        MEM = 2'b01,
        WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } md_funct_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU with zero flag for branch resolution.
module alu
    import execute_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       ctl_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;

    assign shamt = b_i[SH_W-1:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

    always_comb begin
        y_o = '0;
        case (alu_op_t'(ctl_i))
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = WIDTH'($signed(a_i) >>> shamt);
            ALU_LUI:  y_o = b_i;
            default:  y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up when the result is latched.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic [2:0]            funct,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hold,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     op_q, op_d;
    logic             neg_q, neg_d;
    md_funct_t        funct_q, funct_d;
    logic [W-1:0]     res_q, res_d;

    logic         a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf;
    logic [W-1:0] a_mag, b_mag, special_res;

    assign a_signed = (funct != MULHU) && (funct != DIVU) && (funct != REMU);
    assign b_signed = (funct == MUL) || (funct == MULH) || (funct == DIV) || (funct == REM);
    assign sa       = a_signed & a[W-1];
    assign sb       = b_signed & b[W-1];
    assign a_mag    = sa ? -a : a;
    assign b_mag    = sb ? -b : b;
    assign is_div   = funct[2];
    assign div_zero = is_div && (b == '0);
    assign div_ovf  = ((funct == DIV) || (funct == REM)) && (a == MOST_NEG) && (b == '1);

    // REM/REMU (funct[1]) return the remainder; DIV/DIVU the quotient.
    always_comb begin
        if (div_zero) special_res = funct[1] ? a : '1;
        else          special_res = funct[1] ? '0 : MOST_NEG;
    end

    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_hi_n, mul_lo_n;
    logic [W:0]     rem_sh;
    logic           ge;
    logic [W-1:0]   rem_diff, div_hi_n, div_lo_n;
    logic [W-1:0]   step_hi, step_lo;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   div_sel, final_res;

    assign mul_sum  = {1'b0, hi_q} + {1'b0, op_q};
    assign mul_hi_n = lo_q[0] ? mul_sum[W:1] : {1'b0, hi_q[W-1:1]};
    assign mul_lo_n = lo_q[0] ? {mul_sum[0], lo_q[W-1:1]} : {hi_q[0], lo_q[W-1:1]};

    assign rem_sh   = {hi_q, lo_q[W-1]};
    assign ge       = rem_sh >= {1'b0, op_q};
    assign rem_diff = rem_sh[W-1:0] - op_q;
    assign div_hi_n = ge ? rem_diff : rem_sh[W-1:0];
    assign div_lo_n = {lo_q[W-2:0], ge};

    assign step_hi  = funct_q[2] ? div_hi_n : mul_hi_n;
    assign step_lo  = funct_q[2] ? div_lo_n : mul_lo_n;

    assign prod     = {step_hi, step_lo};
    assign prod_s   = neg_q ? -prod : prod;
    assign div_sel  = funct_q[1] ? step_hi : step_lo;

    always_comb begin
        if (funct_q[2])          final_res = neg_q ? -div_sel : div_sel;
        else if (funct_q == MUL) final_res = prod_s[W-1:0];
        else                     final_res = prod_s[2*W-1:W];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        neg_d   = neg_q;
        funct_d = funct_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        state_d = DONE;
                    end else begin
                        funct_d = md_funct_t'(funct);
                        hi_d    = '0;
                        lo_d    = is_div ? a_mag : b_mag;
                        op_d    = is_div ? b_mag : a_mag;
                        // Remainder takes the dividend's sign; everything else the XOR.
                        neg_d   = (is_div && funct[1]) ? sa : (sa ^ sb);
                        cnt_d   = CNT_W'(DATA_WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    res_d   = final_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            funct_q <= MUL;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            funct_q <= funct_d;
            res_q   <= res_d;
        end
    end

    assign done   = (state_q == DONE);
    assign result = res_q;

endmodule

// File: rtl/execute_stage.sv
// Pipelined EX stage: operand forwarding, ALU, iterative muldiv with stall
// handshake, and the registered EX/MEM boundary.
module execute_stage
    import execute_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  mem_stall_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] r_out1,
    input  logic [DATA_WIDTH-1:0] r_out2,
    input  logic [DATA_WIDTH-1:0] imm_ext,
    input  logic [3:0]            alu_control,
    input  logic                  alu_srcA,
    input  logic                  alu_srcB,
    input  logic                  md_op,
    input  logic [2:0]            md_funct,
    input  logic [1:0]            fwdA_sel,
    input  logic [1:0]            fwdB_sel,
    input  logic [DATA_WIDTH-1:0] fwd_mem_data,
    input  logic [DATA_WIDTH-1:0] fwd_wb_data,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  zero,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] ALU_out,
    output logic [DATA_WIDTH-1:0] wdata_out,
    output logic [REG_ADDR_W-1:0] rd_out
);

    logic [DATA_WIDTH-1:0] opA, opB, srcA_val, srcB_val, alu_res, md_res;
    logic                  md_done;

    always_comb begin
        case (fwd_sel_t'(fwdA_sel))
            MEM:     opA = fwd_mem_data;
            WB:      opA = fwd_wb_data;
            default: opA = r_out1;
        endcase
        case (fwd_sel_t'(fwdB_sel))
            MEM:     opB = fwd_mem_data;
            WB:      opB = fwd_wb_data;
            default: opB = r_out2;
        endcase
    end

    assign srcA_val = alu_srcA ? pc : opA;
    assign srcB_val = alu_srcB ? imm_ext : opB;

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .a_i    (srcA_val),
        .b_i    (srcB_val),
        .ctl_i  (alu_control),
        .y_o    (alu_res),
        .zero_o (zero)
    );

    muldiv_unit #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (valid_in & md_op),
        .funct  (md_funct),
        .a      (opA),
        .b      (opB),
        .hold   (mem_stall_in),
        .done   (md_done),
        .result (md_res)
    );

    assign stall_out = mem_stall_in | (valid_in & md_op & ~md_done);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    // An md op still iterating lets a bubble into EX/MEM until its result is ready.
    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!mem_stall_in) begin
            valid_d = valid_in & (~md_op | md_done);
            alu_d   = md_op ? md_res : alu_res;
            wdata_d = opB;
            rd_d    = rd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    assign valid_out = valid_q;
    assign ALU_out   = alu_q;
    assign wdata_out = wdata_q;
    assign rd_out    = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Table-driven bench for execute_stage with a result scoreboard and
// hand-written flush / downstream-stall sequences.
module tb_execute_stage;
    import execute_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned RW = 5;

    logic          clk, rst, flush, mem_stall_in, valid_in;
    logic [W-1:0]  pc, r_out1, r_out2, imm_ext, fwd_mem_data, fwd_wb_data;
    logic [3:0]    alu_control;
    logic          alu_srcA, alu_srcB, md_op;
    logic [2:0]    md_funct;
    logic [1:0]    fwdA_sel, fwdB_sel;
    logic [RW-1:0] rd_in;
    logic          zero, stall_out, valid_out;
    logic [W-1:0]  ALU_out, wdata_out;
    logic [RW-1:0] rd_out;

    execute_stage #(.DATA_WIDTH(W), .REG_ADDR_W(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .mem_stall_in (mem_stall_in),
        .valid_in     (valid_in),
        .pc           (pc),
        .r_out1       (r_out1),
        .r_out2       (r_out2),
        .imm_ext      (imm_ext),
        .alu_control  (alu_control),
        .alu_srcA     (alu_srcA),
        .alu_srcB     (alu_srcB),
        .md_op        (md_op),
        .md_funct     (md_funct),
        .fwdA_sel     (fwdA_sel),
        .fwdB_sel     (fwdB_sel),
        .fwd_mem_data (fwd_mem_data),
        .fwd_wb_data  (fwd_wb_data),
        .rd_in        (rd_in),
        .zero         (zero),
        .stall_out    (stall_out),
        .valid_out    (valid_out),
        .ALU_out      (ALU_out),
        .wdata_out    (wdata_out),
        .rd_out       (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [W-1:0] r1, r2, fmem, fwb, pcv, imm;
        logic [1:0]   fa, fb;
        logic         sa, sb;
        logic [3:0]   ctl;
        logic         md;
        logic [2:0]   fn;
        logic [W-1:0] exp_res, exp_wd;
        int unsigned  exp_stall;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    function automatic vec_t mk(logic [W-1:0] r1, logic [W-1:0] r2,
                                logic [1:0] fa, logic [W-1:0] fmem,
                                logic [1:0] fb, logic [W-1:0] fwb,
                                logic sa, logic [W-1:0] pcv,
                                logic sb, logic [W-1:0] imm,
                                logic [3:0] ctl, logic md, logic [2:0] fn,
                                logic [W-1:0] exp_res, logic [W-1:0] exp_wd,
                                int unsigned exp_stall);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.fa = fa; v.fmem = fmem; v.fb = fb; v.fwb = fwb;
        v.sa = sa; v.pcv = pcv; v.sb = sb; v.imm = imm; v.ctl = ctl;
        v.md = md; v.fn = fn; v.exp_res = exp_res; v.exp_wd = exp_wd;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [RW-1:0] rd);
        r_out1 = v.r1; r_out2 = v.r2; fwd_mem_data = v.fmem; fwd_wb_data = v.fwb;
        fwdA_sel = v.fa; fwdB_sel = v.fb; alu_srcA = v.sa; alu_srcB = v.sb;
        pc = v.pcv; imm_ext = v.imm; alu_control = v.ctl;
        md_op = v.md; md_funct = v.fn; rd_in = rd; valid_in = 1'b1;
    endtask

    task automatic capture(input string nm);
        chk({nm, "_valid"}, {31'd0, valid_out}, 32'd1);
        if (sb_q.size() == 0) begin
            chk({nm, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            chk({nm, "_result"}, ALU_out, sb_q.pop_front());
        end
    endtask

    // Entered just after a rising edge; returns just after the capture edge.
    task automatic issue(input vec_t v, input int unsigned idx);
        int unsigned scnt;
        logic        timed_out;
        string       nm;
        nm = $sformatf("vec%0d", idx);
        drive(v, RW'(idx));
        sb_q.push_back(v.exp_res);
        scnt = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!v.md && i == 0) chk({nm, "_zero"}, {31'd0, zero}, {31'd0, v.exp_res == '0});
            if (!stall_out) begin
                timed_out = 1'b0;
                break;
            end
            scnt++;
        end
        if (timed_out) chk({nm, "_stall_timeout"}, 32'd1, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        md_op    = 1'b0;
        capture(nm);
        chk({nm, "_stall_cycles"}, scnt, v.exp_stall);
        chk({nm, "_wdata"}, wdata_out, v.exp_wd);
        chk({nm, "_rd"}, {27'd0, rd_out}, {27'd0, RW'(idx)});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_stall_in = 1'b0;
        vecs.push_back(mk(32'd5, 32'd3, 2'b01, 32'd7, 2'b00, 32'd0, 0, 0, 0, 0, ALU_ADD, 0, 3'd0, 32'd10, 32'd3, 0));
        vecs.push_back(mk(32'd5, 32'd3, 2'b00, 32'd0, 2'b10, 32'd100, 0, 0, 0, 0, ALU_SUB, 0, 3'd0, 32'hFFFFFFA1, 32'd100, 0));
        vecs.push_back(mk(32'd1, 32'h55, 2'b00, 32'd0, 2'b00, 32'd0, 1, 32'h1000, 1, 32'd4, ALU_ADD, 0, 3'd0, 32'h1004, 32'h55, 0));
        vecs.push_back(mk(32'd9, 32'd9, 2'b11, 32'd1, 2'b11, 32'd2, 0, 0, 0, 0, ALU_SUB, 0, 3'd0, 32'd0, 32'd9, 0));
        vecs.push_back(mk(32'hF0F0, 32'h0FF0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_XOR, 0, 3'd0, 32'hFF00, 32'h0FF0, 0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_SLT, 0, 3'd0, 32'd1, 32'd1, 0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_SLTU, 0, 3'd0, 32'd0, 32'd1, 0));
        vecs.push_back(mk(32'hFFFFFFF9, 32'd2, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, DIV, 32'hFFFFFFFD, 32'd2, 33));
        vecs.push_back(mk(32'hFFFFFFF9, 32'd2, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, REM, 32'hFFFFFFFF, 32'd2, 33));
        vecs.push_back(mk(32'd9, 32'd0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, DIVU, 32'hFFFFFFFF, 32'd0, 1));
        vecs.push_back(mk(32'd9, 32'd0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, REMU, 32'd9, 32'd0, 1));
        vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, DIV, 32'h80000000, 32'hFFFFFFFF, 1));
        vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, REM, 32'd0, 32'hFFFFFFFF, 1));
        vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, MUL, 32'd1, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, MULH, 32'd0, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, MULHU, 32'hFFFFFFFE, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(32'd100, 32'hFFFFFFF9, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, DIV, 32'hFFFFFFF2, 32'hFFFFFFF9, 33));
        vecs.push_back(mk(32'd100, 32'hFFFFFFF9, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, REM, 32'd2, 32'hFFFFFFF9, 33));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd16, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, DIVU, 32'h0FFFFFFF, 32'd16, 33));
        vecs.push_back(mk(32'd1, 32'd7, 2'b10, 0, 2'b00, 32'hFFFFFFFD, 0, 0, 0, 0, ALU_ADD, 1, MUL, 32'hFFFFFFEB, 32'd7, 33));
        vecs.push_back(mk(32'h80000000, 32'd4, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, ALU_ADD, 1, MULHU, 32'd2, 32'd4, 33));

        // Live ADD presented during reset: outputs must still read zero.
        drive(vecs[0], 5'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_alu", ALU_out, 32'd0);
        chk("reset_wdata", wdata_out, 32'd0);
        chk("reset_rd", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;
        valid_in = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) issue(vecs[i], i);

        // Flush in cycle 10 of a DIV, then an ADD, then a fresh DIV must take full latency.
        drive(vecs[7], 5'd1);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_stall", {31'd0, stall_out}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        drive(vecs[0], 5'd2);
        sb_q.push_back(32'd10);
        @(negedge clk);
        chk("flush_stall_drop", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        capture("flush_add");
        issue(vecs[17], 17);

        // Flush while the result sits in DONE must kill it.
        drive(vecs[9], 5'd4);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0; md_op = 1'b0;
        chk("flush_done_valid", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;
        chk("flush_done_idle", {31'd0, valid_out}, 32'd0);

        // Downstream stall held 3 cycles while the DIV sits in DONE.
        drive(vecs[7], 5'd5);
        sb_q.push_back(32'hFFFFFFFD);
        repeat (32) @(posedge clk);
        #1;
        mem_stall_in = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("memstall_stall%0d", i), {31'd0, stall_out}, 32'd1);
            chk($sformatf("memstall_valid%0d", i), {31'd0, valid_out}, 32'd0);
            @(posedge clk); #1;
        end
        mem_stall_in = 1'b0;
        @(negedge clk);
        chk("memstall_release_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0; md_op = 1'b0;
        capture("memstall_div");
        chk("memstall_rd", {27'd0, rd_out}, 32'd5);

        // Downstream stall freezes a captured ALU result.
        issue(vecs[0], 0);
        mem_stall_in = 1'b1;
        drive(vecs[4], 5'd6);
        @(negedge clk);
        chk("hold_stall", {31'd0, stall_out}, 32'd1);
        @(posedge clk); #1;
        chk("hold_valid", {31'd0, valid_out}, 32'd1);
        chk("hold_alu", ALU_out, 32'd10);
        chk("hold_rd", {27'd0, rd_out}, 32'd0);
        mem_stall_in = 1'b0;
        sb_q.push_back(32'hFF00);
        @(posedge clk); #1;
        valid_in = 1'b0;
        capture("hold_release");
        chk("hold_release_rd", {27'd0, rd_out}, 32'd6);

        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
